// File: rtl/cpu6_empty_pipeline_ctrl.sv
// Empty-pipeline drain controller: freezes F/D and bubbles E until the requester retires.
// Optional WAIT-state timeout is compiled in with `define CPU6_DRAIN_TIMEOUT_EN.
module cpu6_empty_pipeline_ctrl #(
   parameter int CNT_WIDTH     = 4,
   parameter int DRAIN_TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 empty_pipeline_reqD,
   input  logic                 ext_stallD,
   input  logic                 flush_req,
   input  logic                 empty_pipeline_reqW,
   output logic                 stallF,
   output logic                 stallD,
   output logic                 flashE,
   output logic                 pipe_empty,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] drain_cnt,
   output logic                 drain_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   stall_q, stall_d;
   logic                   empty_q, empty_d;
   logic                   tmo_q, tmo_d;
   logic                   timeout_hit_s;

`ifdef CPU6_DRAIN_TIMEOUT_EN
   assign timeout_hit_s = (cnt_q == CNT_WIDTH'(DRAIN_TIMEOUT - 1));
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state, counter and output-flop inputs; outputs are registered off state_d.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (empty_pipeline_reqD && !ext_stallD && !flush_req) begin
               state_d = ST_WAIT;
               cnt_d   = {CNT_WIDTH{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (flush_req) begin
               state_d = ST_IDLE;
            end else if (empty_pipeline_reqW) begin
               state_d = ST_DONE;
            end else if (timeout_hit_s) begin
               state_d = ST_IDLE;
               tmo_d   = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = sat_inc(cnt_q);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      stall_d = (state_d != ST_IDLE);
      empty_d = (state_d == ST_DONE);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_WIDTH{1'b0}};
         stall_q <= 1'b0;
         empty_q <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         empty_q <= empty_d;
         tmo_q   <= tmo_d;
      end
   end

   assign stallF        = stall_q;
   assign stallD        = stall_q;
   assign flashE        = stall_q;
   assign busy          = stall_q;
   assign pipe_empty    = empty_q;
   assign drain_cnt     = cnt_q;
   assign drain_timeout = tmo_q;

endmodule

// File: tb/tb_cpu6_empty_pipeline_ctrl.sv
// Directed bench for cpu6_empty_pipeline_ctrl with hand-computed expectations.
module tb_cpu6_empty_pipeline_ctrl;

   logic       clk;
   logic       reset;
   logic       reqD, ext_stallD, flush_req, reqW;
   logic       stallF, stallD, flashE, pipe_empty, busy, drain_timeout;
   logic [3:0] drain_cnt;

   int n_run  = 0;
   int n_fail = 0;

   cpu6_empty_pipeline_ctrl #(.CNT_WIDTH(4), .DRAIN_TIMEOUT(8)) dut (
      .clk                 (clk),
      .reset               (reset),
      .empty_pipeline_reqD (reqD),
      .ext_stallD          (ext_stallD),
      .flush_req           (flush_req),
      .empty_pipeline_reqW (reqW),
      .stallF              (stallF),
      .stallD              (stallD),
      .flashE              (flashE),
      .pipe_empty          (pipe_empty),
      .busy                (busy),
      .drain_cnt           (drain_cnt),
      .drain_timeout       (drain_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packs {stallF,stallD,flashE,busy,pipe_empty,drain_timeout,drain_cnt}.
   task automatic chk(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = {stallF, stallD, flashE, busy, pipe_empty, drain_timeout, drain_cnt};
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; reqD = 1'b0; ext_stallD = 1'b0; flush_req = 1'b0; reqW = 1'b0;
      #12;
      chk("reset_values", 10'b0000_00_0000);
      reset = 1'b1;
      tick();
      chk("idle_after_reset", 10'b0000_00_0000);

      // Nominal drain
      reqD = 1'b1; tick();
      reqD = 1'b0;
      chk("nom_wait_entry", 10'b1111_00_0000);
      tick();
      chk("nom_wait_cnt1", 10'b1111_00_0001);
      tick();
      chk("nom_wait_cnt2", 10'b1111_00_0010);
      reqW = 1'b1; tick();
      reqW = 1'b0;
      chk("nom_done", 10'b1111_10_0010);
      tick();
      chk("nom_idle", 10'b0000_00_0010);

      // Blocked acceptance by ext_stallD
      reqD = 1'b1; ext_stallD = 1'b1; tick();
      chk("blocked_c1", 10'b0000_00_0010);
      tick();
      chk("blocked_c2", 10'b0000_00_0010);
      ext_stallD = 1'b0; tick();
      reqD = 1'b0;
      chk("blocked_release", 10'b1111_00_0000);

      // Flush abort in WAIT
      tick();
      flush_req = 1'b1; tick();
      flush_req = 1'b0;
      chk("flush_abort", 10'b0000_00_0001);

      // reqD together with flush is not accepted
      reqD = 1'b1; flush_req = 1'b1; tick();
      flush_req = 1'b0; reqD = 1'b0;
      chk("reqD_with_flush", 10'b0000_00_0001);

      // flush/reqW collision: flush wins
      reqD = 1'b1; tick();
      reqD = 1'b0;
      chk("coll_wait", 10'b1111_00_0000);
      reqW = 1'b1; flush_req = 1'b1; tick();
      reqW = 1'b0; flush_req = 1'b0;
      chk("coll_flush_wins", 10'b0000_00_0000);
      tick();
      chk("coll_no_empty", 10'b0000_00_0000);

      // Stray reqW in IDLE
      reqW = 1'b1; tick();
      reqW = 1'b0;
      chk("stray_reqW", 10'b0000_00_0000);

      // Back-to-back, reqD held during WAIT/DONE, flush in DONE ignored
      reqD = 1'b1; tick();
      chk("b2b_wait1", 10'b1111_00_0000);
      reqW = 1'b1; tick();
      reqW = 1'b0; flush_req = 1'b1;
      chk("b2b_done1", 10'b1111_10_0000);
      tick();
      flush_req = 1'b0;
      chk("b2b_idle", 10'b0000_00_0000);
      tick();
      reqD = 1'b0;
      chk("b2b_wait2", 10'b1111_00_0000);
      tick();
      reqW = 1'b1; tick();
      reqW = 1'b0;
      chk("b2b_done2", 10'b1111_10_0001);
      tick();
      chk("b2b_idle2", 10'b0000_00_0001);

      // Timeout / saturation
      reqD = 1'b1; tick();
      reqD = 1'b0;
      chk("tmo_entry", 10'b1111_00_0000);
`ifdef CPU6_DRAIN_TIMEOUT_EN
      repeat (7) tick();
      chk("tmo_last_wait", 10'b1111_00_0111);
      tick();
      chk("tmo_pulse", 10'b0000_01_0111);
      tick();
      chk("tmo_pulse_end", 10'b0000_00_0111);
`else
      repeat (20) tick();
      chk("no_tmo_saturate", 10'b1111_00_1111);
      flush_req = 1'b1; tick();
      flush_req = 1'b0;
      chk("no_tmo_exit", 10'b0000_00_1111);
`endif

      // Asynchronous reset mid-WAIT
      reqD = 1'b1; tick();
      reqD = 1'b0;
      tick(); tick();
      chk("pre_reset_wait", 10'b1111_00_0010);
      #1 reset = 1'b0;
      #1;
      chk("async_reset", 10'b0000_00_0000);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("post_reset_idle", 10'b0000_00_0000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu6_empty_pipeline_ctrl.md
# cpu6_empty_pipeline_ctrl

Drain controller that responds to the empty-pipeline request carried down the cpu6 pipeline. When a decode-stage instruction requests an empty pipeline (CSR/fence-class operations), the block lets the requester advance, then freezes fetch/decode and injects bubbles into execute until the same request arrives at writeback through the MEM/WB register. It then signals a guaranteed-empty cycle and releases the front end. It sits in the hazard unit, beside the stall/flush generation.

## Interface

Parameters:
- CNT_WIDTH, 4, width of the drain cycle counter.
- DRAIN_TIMEOUT, 8, WAIT-state cycle limit (used only with the timeout feature); must be ≥4 and ≤2^CNT_WIDTH−1.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; single clock domain.
- empty_pipeline_reqD  input  1  decode-stage instruction requests an empty pipeline.
- ext_stallD  input  1  decode held by another hazard this cycle; requester does not advance.
- flush_req  input  1  pipeline flush of everything younger than W (branch/exception); kills the requester.
- empty_pipeline_reqW  input  1  request has reached writeback (from MEM/WB register).
- stallF  output  1  hold fetch.
- stallD  output  1  hold decode.
- flashE  output  1  inject a bubble into the ID/EX register.
- pipe_empty  output  1  one-cycle pulse: E, M, W contain no valid instruction.
- busy  output  1  controller not IDLE.
- drain_cnt  output  CNT_WIDTH  cycles spent in WAIT for the current request.
- drain_timeout  output  1  one-cycle pulse: drain abandoned on timeout.

## Operation

- States: IDLE, WAIT, DONE (2-bit encoding; IDLE = 0).
- IDLE: stallF = stallD = flashE = busy = 0. If empty_pipeline_reqD & ~ext_stallD & ~flush_req → WAIT, drain_cnt ← 0. Else stay. empty_pipeline_reqW in IDLE is ignored.
- WAIT: stallF = stallD = flashE = busy = 1 (Moore, decoded from state only). Priority, highest first:
  - flush_req → IDLE; no pipe_empty.
  - empty_pipeline_reqW → DONE.
  - timeout (if compiled in) → IDLE with drain_timeout.
  - else stay; drain_cnt increments, saturating at all-ones.
- DONE: stallF = stallD = flashE = busy = 1, pipe_empty = 1; unconditionally → IDLE. flush_req in DONE has no effect on the transition.
- drain_cnt holds its value in IDLE and DONE; it is cleared only on WAIT entry and on reset.
- Reset (any state, any time): state → IDLE, drain_cnt → 0, all outputs 0 immediately (asynchronous).

## Timing

- Reset values: stallF, stallD, flashE, pipe_empty, busy, drain_timeout = 0; drain_cnt = 0.
- Request accepted at cycle t (reqD=1, ext_stallD=0, flush_req=0) → WAIT at t+1. Requester is in E at t+1, M at t+2, W at t+3.
- Nominal: reqW=1 at t+3 → DONE at t+4 (pipe_empty=1), IDLE at t+5. Stalls are asserted t+1…t+4. drain_cnt reads 2 in DONE.
- Back-to-back: a new reqD sampled in the IDLE cycle t+5 is accepted. reqD during WAIT/DONE is held by stallD and not re-captured.
- Simultaneous flush_req and reqW in WAIT: flush wins → IDLE.
- All outputs are registered-state decodes; no input-to-output combinational path.

## Configuration

- Macro CPU6_DRAIN_TIMEOUT_EN.
- Defined: in WAIT, if drain_cnt == DRAIN_TIMEOUT−1 and neither flush_req nor reqW is set, go to IDLE and pulse drain_timeout for one cycle (the cycle in which the state is IDLE after the transition is registered, i.e. a registered pulse).
- Undefined: no timeout. WAIT persists until reqW or flush_req. drain_timeout is tied to 0.

## Test plan

- Reset: hold reset=0 mid-WAIT → all outputs 0 and drain_cnt=0 immediately; after release, state is IDLE.
- Nominal drain: reqD=1 at cycle 10, reqW=1 at cycle 13 → stalls 11–14, pipe_empty only at 14, drain_cnt=2, busy=0 at 15.
- Blocked acceptance: reqD=1 with ext_stallD=1 for cycles 10–11, released at 12 → WAIT entered at 13. reqD with flush_req=1 → stays IDLE.
- Flush abort: flush_req=1 at cycle 12 while in WAIT, and also a flush_req/reqW collision on a second request → IDLE next cycle, pipe_empty never asserted.
- Timeout (CPU6_DRAIN_TIMEOUT_EN, DRAIN_TIMEOUT=8): no reqW after acceptance → drain_timeout pulses once, stalls drop, drain_cnt=7. Without the macro → still in WAIT after 20 cycles, drain_timeout=0, drain_cnt saturates at 15.
- Stray reqW in IDLE, then back-to-back requests → no state change for the stray reqW; the second request is accepted in the first IDLE cycle after DONE.
